// File: rtl/lava_round_sequencer.sv
// Round flow controller for the lava wall game: owns the round FSM, the lives
// count and the score-driven lava speed schedule. Everything advances on game_tick.
module lava_round_sequencer #(
   parameter int START_LIVES = 3,
   parameter int BOOST_STEP  = 100,
   parameter int MAX_LEVEL   = 7,
   parameter int DEATH_TICKS = 90,
   parameter int HOLD_TICKS  = 60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        game_tick,
   input  logic        any_input_level,
   input  logic        hit_lava_wall,
   input  logic        reached_goal,
   input  logic [15:0] score,
   output logic [2:0]  game_state,
   output logic        freeze,
   output logic [1:0]  lives,
   output logic [2:0]  speed_level,
   output logic        speed_boost_pulse,
   output logic        round_restart
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PLAY  = 3'd1,
      S_DYING = 3'd2,
      S_WIN   = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   localparam logic [1:0]  LIVES_INIT = 2'(START_LIVES);
   localparam logic [16:0] THR_STEP   = 17'(BOOST_STEP);
   localparam logic [2:0]  LEVEL_MAX  = 3'(MAX_LEVEL);
   localparam logic [7:0]  DEATH_LAST = 8'(DEATH_TICKS - 1);
   localparam logic [7:0]  HOLD_CNT   = 8'(HOLD_TICKS);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  lives_q, lives_d;
   logic [2:0]  level_q, level_d;
   logic [16:0] thr_q, thr_d;
   logic        freeze_q, freeze_d;
   logic        boost_q, boost_d;
   logic        restart_q, restart_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         lives_q   <= LIVES_INIT;
         level_q   <= '0;
         thr_q     <= THR_STEP;
         freeze_q  <= 1'b1;
         boost_q   <= 1'b0;
         restart_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lives_q   <= lives_d;
         level_q   <= level_d;
         thr_q     <= thr_d;
         freeze_q  <= freeze_d;
         boost_q   <= boost_d;
         restart_q <= restart_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lives_d   = lives_q;
      level_d   = level_q;
      thr_d     = thr_q;
      boost_d   = 1'b0;
      restart_d = 1'b0;
      if (game_tick) begin
         case (state_q)
            S_IDLE: begin
               if (any_input_level) begin
                  state_d   = S_PLAY;
                  cnt_d     = '0;
                  restart_d = 1'b1;
               end
            end
            S_PLAY: begin
               // Goal beats collision; a boost is only considered when staying in PLAY.
               if (reached_goal) begin
                  state_d = S_WIN;
                  cnt_d   = '0;
               end else if (hit_lava_wall) begin
                  state_d = S_DYING;
                  cnt_d   = '0;
                  if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
               end else if (({1'b0, score} >= thr_q) && (level_q < LEVEL_MAX)) begin
                  level_d = level_q + 3'd1;
                  thr_d   = thr_q + THR_STEP;
                  boost_d = 1'b1;
               end
            end
            S_DYING: begin
               if (cnt_q == DEATH_LAST) begin
                  cnt_d = '0;
                  if (lives_q == 2'd0) begin
                     state_d = S_OVER;
                  end else begin
                     state_d   = S_PLAY;
                     restart_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            S_WIN, S_OVER: begin
               if (cnt_q == HOLD_CNT) begin
                  if (any_input_level) begin
                     state_d = S_IDLE;
                     cnt_d   = '0;
                     lives_d = LIVES_INIT;
                     level_d = '0;
                     thr_d   = THR_STEP;
                  end
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
               lives_d = LIVES_INIT;
               level_d = '0;
               thr_d   = THR_STEP;
            end
         endcase
      end
      freeze_d = (state_d != S_PLAY);
   end

   assign game_state        = state_q;
   assign freeze            = freeze_q;
   assign lives             = lives_q;
   assign speed_level       = level_q;
   assign speed_boost_pulse = boost_q;
   assign round_restart     = restart_q;

endmodule
